data_ram: RTL and testbench

- Single-port, word-addressed data RAM used as the backing store behind the fully-associative cache controller.
- Synchronous write; combinational (asynchronous) read.
- Asynchronous active-low clear zeroes the whole array.
- Locations 0–7 are exported continuously as monitor outputs for debug and bench visibility.

---
 rtl/data_ram.sv | 51 +++++
 tb/tb_data_ram.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port word-addressed data RAM with async clear and monitor taps
module data_ram #(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enab,
  input  logic               rw,
  input  logic [a_width-1:0] Addr,
  input  logic [d_width-1:0] data_in,
  output logic [d_width-1:0] mem0,
  output logic [d_width-1:0] mem1,
  output logic [d_width-1:0] mem2,
  output logic [d_width-1:0] mem3,
  output logic [d_width-1:0] mem4,
  output logic [d_width-1:0] mem5,
  output logic [d_width-1:0] mem6,
  output logic [d_width-1:0] mem7,
  output logic [d_width-1:0] data_out
);

  localparam int depth = 1 << a_width;

  logic [d_width-1:0] mem [depth];

  // Clear wipes every word immediately and outranks any write; otherwise enabled writes land on the edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (enab && rw) begin
      mem[Addr] <= data_in;
    end
  end

  // Read path is combinational and driven to zero whenever no read is in progress.
  assign data_out = (enab && !rw) ? mem[Addr] : '0;

  // Debug taps on the low eight words, independent of enab/rw.
  assign mem0 = mem[0];
  assign mem1 = mem[1];
  assign mem2 = mem[2];
  assign mem3 = mem[3];
  assign mem4 = mem[4];
  assign mem5 = mem[5];
  assign mem6 = mem[6];
  assign mem7 = mem[7];

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - directed self-checking bench for data_ram
module tb_data_ram;

    logic       clk = 1'b0;
    logic       clr;
    logic       enab;
    logic       rw;
    logic [7:0] Addr;
    logic [7:0] data_in;
    logic [7:0] m [8];
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    data_ram #(.d_width(8), .a_width(8)) dut (
        .clk(clk), .clr(clr), .enab(enab), .rw(rw), .Addr(Addr), .data_in(data_in),
        .mem0(m[0]), .mem1(m[1]), .mem2(m[2]), .mem3(m[3]),
        .mem4(m[4]), .mem5(m[5]), .mem6(m[6]), .mem7(m[7]),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        enab = 1'b1; rw = 1'b1; Addr = a; data_in = d;
        @(posedge clk);
        #1;
        enab = 1'b0; rw = 1'b0;
    endtask

    initial begin
        clr = 1'b0; enab = 1'b0; rw = 1'b0; Addr = 8'h00; data_in = 8'h00;

        #12;
        for (int i = 0; i < 8; i++) check("reset_mon", m[i], 8'h00);
        check("reset_dout", data_out, 8'h00);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 8; i++) do_write(i[7:0], 8'hAA);
        check("pre_clr_mem3", m[3], 8'hAA);
        check("pre_clr_mem7", m[7], 8'hAA);
        #1;
        clr = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) check("clr_async_mon", m[i], 8'h00);
        enab = 1'b1; rw = 1'b0; Addr = 8'h03;
        #1;
        check("clr_read3", data_out, 8'h00);
        enab = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        do_write(8'h05, 8'h3C);
        check("wr_mem5", m[5], 8'h3C);
        for (int i = 0; i < 8; i++) if (i != 5) check("wr_other_mon", m[i], 8'h00);
        enab = 1'b1; rw = 1'b0; Addr = 8'h05;
        #1;
        check("rd_addr5", data_out, 8'h3C);
        enab = 1'b0;

        do_write(8'hFF, 8'h77);
        check("upper_mem5", m[5], 8'h3C);
        check("upper_mem7", m[7], 8'h00);
        check("upper_mem0", m[0], 8'h00);
        enab = 1'b1; rw = 1'b0; Addr = 8'hFF;
        #1;
        check("rd_addrFF", data_out, 8'h77);
        Addr = 8'h07;
        #1;
        check("rd_addr07", data_out, 8'h00);
        enab = 1'b0;

        @(negedge clk);
        enab = 1'b0; rw = 1'b1; Addr = 8'h02; data_in = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        check("dis_mem2", m[2], 8'h00);
        check("dis_dout_w", data_out, 8'h00);
        rw = 1'b0;
        #1;
        check("dis_dout_r", data_out, 8'h00);
        enab = 1'b1; rw = 1'b1; Addr = 8'h05;
        #1;
        check("wrmode_dout", data_out, 8'h00);
        enab = 1'b0; rw = 1'b0;

        @(negedge clk);
        clr = 1'b0; enab = 1'b1; rw = 1'b1; Addr = 8'h01; data_in = 8'h99;
        @(posedge clk);
        #1;
        check("prio_mem1", m[1], 8'h00);
        check("prio_mem5", m[5], 8'h00);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("post_clr_mem1", m[1], 8'h99);
        rw = 1'b0; Addr = 8'hFF;
        #1;
        check("post_clr_rdFF", data_out, 8'h00);
        enab = 1'b0;

        @(negedge clk);
        enab = 1'b1; rw = 1'b1; Addr = 8'h04; data_in = 8'h01;
        @(negedge clk);
        Addr = 8'h05; data_in = 8'h02;
        @(negedge clk);
        Addr = 8'h06; data_in = 8'h03;
        @(negedge clk);
        rw = 1'b0; Addr = 8'h04;
        #1;
        check("b2b_rd4", data_out, 8'h01);
        @(negedge clk);
        Addr = 8'h05;
        #1;
        check("b2b_rd5", data_out, 8'h02);
        @(negedge clk);
        Addr = 8'h06;
        #1;
        check("b2b_rd6", data_out, 8'h03);
        check("b2b_mem4", m[4], 8'h01);
        check("b2b_mem5", m[5], 8'h02);
        check("b2b_mem6", m[6], 8'h03);
        check("b2b_mem1", m[1], 8'h99);
        enab = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
